// File: rtl/vga_timing_gen.sv
// Raster timing for the VGA output. Produces the counters that address the frame buffer,
// then realigns sync, blanking and the returned colour to the same output edge.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int PIPE_DELAY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       colour,
  output logic [9:0] counter_H,
  output logic [9:0] counter_V,
  output logic       h_sync,
  output logic       v_sync,
  output logic [5:0] rgb_out,
  output logic       display_on,
  output logic       frame_start
);

  localparam logic [9:0] H_MAX    = 10'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_MAX    = 10'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FRONT + V_SYNC);
  // Idle value of one delay stage: {hs, vs, act}
  localparam logic [2:0] RAW_IDLE = 3'b110;

  logic [9:0] r_h;
  logic [9:0] r_v;
  logic       r_hs;
  logic       r_vs;
  logic       r_de;
  logic       r_fs;
  logic [5:0] r_rgb;
  logic       w_h_max;
  logic       w_v_max;
  logic       w_hs_raw;
  logic       w_vs_raw;
  logic       w_act_raw;
  logic [2:0] w_raw;
  logic [2:0] w_del;

  // Raw qualifiers straight from the current counter values
  always_comb begin
    w_h_max   = (r_h == H_MAX);
    w_v_max   = (r_v == V_MAX);
    w_hs_raw  = !((r_h >= HS_START) && (r_h < HS_END));
    w_vs_raw  = !((r_v >= VS_START) && (r_v < VS_END));
    w_act_raw = (r_h < H_VIS) && (r_v < V_VIS);
  end

  assign w_raw = {w_hs_raw, w_vs_raw, w_act_raw};

  // Horizontal and vertical position counters
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_h <= 10'd0;
      r_v <= 10'd0;
    end else if (w_h_max) begin
      r_h <= 10'd0;
      r_v <= w_v_max ? 10'd0 : (r_v + 10'd1);
    end else begin
      r_h <= r_h + 10'd1;
    end
  end

  generate
    if (PIPE_DELAY == 0) begin : g_nodelay
      assign w_del = w_raw;
    end else begin : g_pipe
      logic [2:0] r_pipe [PIPE_DELAY];

      // Delay line matching the frame-buffer lookup latency
      always_ff @(posedge clk) begin
        if (!reset) begin
          for (int i = 0; i < PIPE_DELAY; i++) r_pipe[i] <= RAW_IDLE;
        end else begin
          r_pipe[0] <= w_raw;
          for (int i = 1; i < PIPE_DELAY; i++) r_pipe[i] <= r_pipe[i-1];
        end
      end

      assign w_del = r_pipe[PIPE_DELAY-1];
    end
  endgenerate

  // Output register; colour only reaches the pins inside the visible area
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hs  <= 1'b1;
      r_vs  <= 1'b1;
      r_de  <= 1'b0;
      r_rgb <= 6'b000000;
      r_fs  <= 1'b0;
    end else begin
      r_hs  <= w_del[2];
      r_vs  <= w_del[1];
      r_de  <= w_del[0];
      r_rgb <= (w_del[0] && colour) ? 6'b111111 : 6'b000000;
      r_fs  <= w_h_max && w_v_max;
    end
  end

  assign counter_H   = r_h;
  assign counter_V   = r_v;
  assign h_sync      = r_hs;
  assign v_sync      = r_vs;
  assign display_on  = r_de;
  assign rgb_out     = r_rgb;
  assign frame_start = r_fs;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size 640x480 instance for line timing and a
// miniature raster instance so whole frames fit in a short run.
module tb_vga_timing_gen;

  localparam int S_HA = 16, S_HF = 2, S_HS = 4, S_HB = 3;
  localparam int S_VA = 6,  S_VF = 1, S_VS = 2, S_VB = 2;
  localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
  localparam int S_VT = S_VA + S_VF + S_VS + S_VB;
  localparam int S_PD = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       col_b = 1'b0;
  logic       col_s = 1'b0;
  logic [9:0] bh, bv, sh, sv;
  logic       bhs, bvs, bde, bfs, shs, svs, sde, sfs;
  logic [5:0] brgb, srgb;

  int n_cmp = 0;
  int n_bad = 0;
  int col_hist [0:1023];

  always #5 clk = ~clk;

  vga_timing_gen #(.PIPE_DELAY(1)) u_big (
    .clk(clk), .reset(reset), .colour(col_b),
    .counter_H(bh), .counter_V(bv), .h_sync(bhs), .v_sync(bvs),
    .rgb_out(brgb), .display_on(bde), .frame_start(bfs)
  );

  vga_timing_gen #(
    .H_ACTIVE(S_HA), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .V_ACTIVE(S_VA), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
    .PIPE_DELAY(S_PD)
  ) u_small (
    .clk(clk), .reset(reset), .colour(col_s),
    .counter_H(sh), .counter_V(sv), .h_sync(shs), .v_sync(svs),
    .rgb_out(srgb), .display_on(sde), .frame_start(sfs)
  );

  function automatic int s_h(input int t);
    return t % S_HT;
  endfunction

  function automatic int s_v(input int t);
    return (t / S_HT) % S_VT;
  endfunction

  // Hold reset for n edges; returns at the negedge of the first cycle after release
  task automatic do_reset(input int n);
    reset = 1'b0;
    repeat (n) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset;
    do_reset(3);
    n_cmp += 6;
    if (bh !== 10'd0 || bv !== 10'd0) begin n_bad++; $display("FAIL reset_counters got %0d,%0d exp 0,0", bh, bv); end
    if (bhs !== 1'b1) begin n_bad++; $display("FAIL reset_h_sync got %b exp 1", bhs); end
    if (bvs !== 1'b1) begin n_bad++; $display("FAIL reset_v_sync got %b exp 1", bvs); end
    if (brgb !== 6'd0) begin n_bad++; $display("FAIL reset_rgb got %h exp 00", brgb); end
    if (bde !== 1'b0) begin n_bad++; $display("FAIL reset_display_on got %b exp 0", bde); end
    if (bfs !== 1'b0) begin n_bad++; $display("FAIL reset_frame_start got %b exp 0", bfs); end
  endtask

  task automatic test_mid_reset;
    do_reset(2);
    col_b = 1'b1;
    repeat (300) @(negedge clk);
    n_cmp++;
    if (bh !== 10'd300) begin n_bad++; $display("FAIL midreset_pre_H got %0d exp 300", bh); end
    reset = 1'b0;
    @(negedge clk);
    n_cmp += 4;
    if (bh !== 10'd0 || bv !== 10'd0) begin n_bad++; $display("FAIL midreset_counters got %0d,%0d exp 0,0", bh, bv); end
    if (bhs !== 1'b1 || bvs !== 1'b1) begin n_bad++; $display("FAIL midreset_sync got %b%b exp 11", bhs, bvs); end
    if (brgb !== 6'd0 || bde !== 1'b0) begin n_bad++; $display("FAIL midreset_rgb got %h/%b exp 00/0", brgb, bde); end
    if (sh !== 10'd0 || shs !== 1'b1 || svs !== 1'b1 || srgb !== 6'd0) begin
      n_bad++; $display("FAIL midreset_small got H=%0d hs=%b vs=%b rgb=%h exp 0 1 1 00", sh, shs, svs, srgb);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (bh !== 10'(i) || bv !== 10'd0) begin n_bad++; $display("FAIL midreset_step got %0d,%0d exp %0d,0", bh, bv, i); end
      @(negedge clk);
    end
  endtask

  task automatic test_horizontal;
    int falls[$];
    int rises[$];
    logic prev_hs;
    int de_cnt;
    do_reset(2);
    col_b = 1'b1;
    prev_hs = 1'b1;
    de_cnt = 0;
    for (int t = 0; t < 2500; t++) begin
      int s, h, v;
      logic ehs, ede;
      s = t - 2;
      h = (s >= 0) ? s % 800 : 0;
      v = (s >= 0) ? (s / 800) % 525 : 0;
      ehs = (s >= 0) ? !(h >= 656 && h < 752) : 1'b1;
      ede = (s >= 0) ? (h < 640 && v < 480) : 1'b0;
      n_cmp += 4;
      if (bh !== 10'(t % 800) || bv !== 10'(t / 800)) begin
        n_bad++; $display("FAIL horiz_counters t=%0d got %0d,%0d exp %0d,%0d", t, bh, bv, t % 800, t / 800);
      end
      if (bhs !== ehs) begin n_bad++; $display("FAIL horiz_h_sync t=%0d got %b exp %b", t, bhs, ehs); end
      if (bde !== ede) begin n_bad++; $display("FAIL horiz_display_on t=%0d got %b exp %b", t, bde, ede); end
      if (brgb !== (ede ? 6'h3f : 6'h00)) begin n_bad++; $display("FAIL horiz_rgb t=%0d got %h exp %h", t, brgb, ede ? 6'h3f : 6'h00); end
      if (prev_hs === 1'b1 && bhs === 1'b0) falls.push_back(t);
      if (prev_hs === 1'b0 && bhs === 1'b1) rises.push_back(t);
      if (t >= 2 && t < 802 && bde === 1'b1) de_cnt++;
      prev_hs = bhs;
      @(negedge clk);
    end
    n_cmp += 2;
    if (de_cnt != 640) begin n_bad++; $display("FAIL horiz_de_count got %0d exp 640", de_cnt); end
    if (falls.size() != 3 || rises.size() != 3) begin
      n_bad++; $display("FAIL horiz_edges got %0d falls %0d rises exp 3 3", falls.size(), rises.size());
    end else begin
      n_cmp++;
      if (falls[0] != 658) begin n_bad++; $display("FAIL horiz_first_fall got %0d exp 658", falls[0]); end
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (rises[i] - falls[i] != 96) begin n_bad++; $display("FAIL horiz_low_width got %0d exp 96", rises[i] - falls[i]); end
        if (i > 0) begin
          n_cmp++;
          if (falls[i] - falls[i-1] != 800) begin n_bad++; $display("FAIL horiz_period got %0d exp 800", falls[i] - falls[i-1]); end
        end
      end
    end
  endtask

  // mode 0: random colour, 1: colour held high, 2: colour marks delayed H==5
  task automatic test_raster_model(input int mode, input int ncyc);
    int fs_cnt;
    do_reset(2);
    fs_cnt = 0;
    for (int t = 0; t < ncyc; t++) begin
      int s, h, v;
      logic ehs, evs, ede, efs;
      logic [5:0] ergb;
      s = t - 1 - S_PD;
      ehs = 1'b1; evs = 1'b1; ede = 1'b0; ergb = 6'd0;
      if (s >= 0) begin
        h = s_h(s);
        v = s_v(s);
        ehs = !(h >= S_HA + S_HF && h < S_HA + S_HF + S_HS);
        evs = !(v >= S_VA + S_VF && v < S_VA + S_VF + S_VS);
        ede = (h < S_HA) && (v < S_VA);
        ergb = (ede && col_hist[t-1] != 0) ? 6'h3f : 6'h00;
      end
      efs = (t >= 1) && s_h(t-1) == S_HT - 1 && s_v(t-1) == S_VT - 1;
      n_cmp += 6;
      if (sh !== 10'(s_h(t)) || sv !== 10'(s_v(t))) begin
        n_bad++; $display("FAIL model_counters m%0d t=%0d got %0d,%0d exp %0d,%0d", mode, t, sh, sv, s_h(t), s_v(t));
      end
      if (shs !== ehs) begin n_bad++; $display("FAIL model_h_sync m%0d t=%0d got %b exp %b", mode, t, shs, ehs); end
      if (svs !== evs) begin n_bad++; $display("FAIL model_v_sync m%0d t=%0d got %b exp %b", mode, t, svs, evs); end
      if (sde !== ede) begin n_bad++; $display("FAIL model_display_on m%0d t=%0d got %b exp %b", mode, t, sde, ede); end
      if (srgb !== ergb) begin n_bad++; $display("FAIL model_rgb m%0d t=%0d got %h exp %h", mode, t, srgb, ergb); end
      if (sfs !== efs) begin n_bad++; $display("FAIL model_frame_start m%0d t=%0d got %b exp %b", mode, t, sfs, efs); end
      if (sfs === 1'b1) fs_cnt++;
      case (mode)
        0:       col_s = 1'($urandom_range(1, 0));
        1:       col_s = 1'b1;
        default: col_s = (t >= S_PD) && (s_h(t - S_PD) == 5);
      endcase
      col_hist[t] = int'(col_s);
      @(negedge clk);
    end
    n_cmp++;
    if (fs_cnt != (ncyc - 1) / (S_HT * S_VT)) begin
      n_bad++; $display("FAIL model_fs_count m%0d got %0d exp %0d", mode, fs_cnt, (ncyc - 1) / (S_HT * S_VT));
    end
  endtask

  task automatic test_colour_align;
    do_reset(2);
    for (int t = 0; t < S_HT + 3; t++) begin
      n_cmp++;
      if (srgb !== ((t == 8) ? 6'h3f : 6'h00)) begin
        n_bad++; $display("FAIL align_rgb t=%0d got %h exp %h", t, srgb, (t == 8) ? 6'h3f : 6'h00);
      end
      col_s = (t >= S_PD) && (s_h(t - S_PD) == 5);
      @(negedge clk);
    end
  endtask

  task automatic test_wrap;
    do_reset(2);
    col_s = 1'b0;
    repeat (S_HT * S_VT - 1) @(negedge clk);
    n_cmp += 3;
    if (sh !== 10'(S_HT - 1) || sv !== 10'(S_VT - 1) || sfs !== 1'b0) begin
      n_bad++; $display("FAIL wrap_max got %0d,%0d fs=%b exp %0d,%0d fs=0", sh, sv, sfs, S_HT - 1, S_VT - 1);
    end
    @(negedge clk);
    if (sh !== 10'd0 || sv !== 10'd0 || sfs !== 1'b1) begin
      n_bad++; $display("FAIL wrap_zero got %0d,%0d fs=%b exp 0,0 fs=1", sh, sv, sfs);
    end
    @(negedge clk);
    if (sh !== 10'd1 || sv !== 10'd0 || sfs !== 1'b0) begin
      n_bad++; $display("FAIL wrap_next got %0d,%0d fs=%b exp 1,0 fs=0", sh, sv, sfs);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) col_hist[i] = 0;
    test_reset();
    test_mid_reset();
    test_horizontal();
    test_raster_model(0, 600);
    test_raster_model(1, 600);
    test_raster_model(2, 600);
    test_colour_align();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
